// File: rtl/ysyx_22041412_axi_master_bridge.sv
// ysyx_22041412_axi_master_bridge
// Converts the IF/MEM arbiter's request/done handshake into AXI4 master
// channels. Reads (AR/R) and writes (AW/W/B) run as independent FSMs, and each
// accepted request ends with exactly one single-cycle done pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   r_valid_i/r_addr_i/...   read request from arbiter, held until r_ready_o
//   r_ready_o, data_read_o   read done pulse and latest read beat
//   w_valid_i/w_addr_i/...   write request from arbiter, held until w_ready_o
//   w_ready_o                write done pulse
//   axi_ar_*, axi_r_*        AXI read address / read data channels
//   axi_aw_*, axi_w_*, axi_b_* AXI write address / data / response channels
//   resp_err_o               sticky non-OKAY response flag (AXI_RESP_CHECK_EN only)
//
// Optional feature macro: AXI_RESP_CHECK_EN
module ysyx_22041412_axi_master_bridge #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MAX_LEN        = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        r_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   r_addr_i,
    input  logic [7:0]                  r_size_i,
    input  logic [7:0]                  r_len_i,
    output logic                        r_ready_o,
    output logic [AXI_DATA_WIDTH-1:0]   data_read_o,
    input  logic                        w_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   w_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   rw_w_data_i,
    input  logic [7:0]                  w_size_i,
    input  logic [7:0]                  w_len_i,
    output logic                        w_ready_o,
    output logic                        axi_ar_valid,
    input  logic                        axi_ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
    output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
    output logic [7:0]                  axi_ar_len,
    output logic [2:0]                  axi_ar_size,
    output logic [1:0]                  axi_ar_burst,
    input  logic                        axi_r_valid,
    output logic                        axi_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
    input  logic [1:0]                  axi_r_resp,
    input  logic                        axi_r_last,
    input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
    output logic                        axi_aw_valid,
    input  logic                        axi_aw_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
    output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
    output logic [7:0]                  axi_aw_len,
    output logic [2:0]                  axi_aw_size,
    output logic [1:0]                  axi_aw_burst,
    output logic                        axi_w_valid,
    input  logic                        axi_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
    output logic                        axi_w_last,
    input  logic                        axi_b_valid,
    output logic                        axi_b_ready,
    input  logic [1:0]                  axi_b_resp,
    input  logic [AXI_ID_WIDTH-1:0]     axi_b_id
`ifdef AXI_RESP_CHECK_EN
    ,
    output logic                        resp_err_o
`endif
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rState_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} wState_t;

    // Size codes above 3 (8 bytes) are clamped to a full 64-bit beat.
    function automatic logic [2:0] clampSize(input logic [2:0] s);
        return (s > 3'd3) ? 3'd3 : s;
    endfunction

    rState_t                     rState_q, rState_d;
    logic [AXI_ADDR_WIDTH-1:0]   rAddr_q, rAddr_d;
    logic [2:0]                  rSize_q, rSize_d;
    logic [7:0]                  rLen_q, rLen_d;
    logic [7:0]                  rCnt_q, rCnt_d;
    logic [AXI_DATA_WIDTH-1:0]   rData_q, rData_d;
    logic                        rBeat;

    wState_t                     wState_q, wState_d;
    logic [AXI_ADDR_WIDTH-1:0]   wAddr_q, wAddr_d;
    logic [AXI_DATA_WIDTH-1:0]   wData_q, wData_d;
    logic [2:0]                  wSize_q, wSize_d;
    logic [STRB_W-1:0]           wStrb_q, wStrb_d;
    logic                        awDone_q, awDone_d;
    logic                        wDone_q, wDone_d;
    logic                        awDoneNow, wDoneNow;
    logic [7:0]                  laneMask;
    logic [15:0]                 strbWide;

    always_ff @(posedge clk) begin
        if (rst) begin
            rState_q <= R_IDLE;
            rAddr_q  <= '0;
            rSize_q  <= '0;
            rLen_q   <= '0;
            rCnt_q   <= '0;
            rData_q  <= '0;
        end else begin
            rState_q <= rState_d;
            rAddr_q  <= rAddr_d;
            rSize_q  <= rSize_d;
            rLen_q   <= rLen_d;
            rCnt_q   <= rCnt_d;
            rData_q  <= rData_d;
        end
    end

    // A beat is accepted only in R_DATA, so stray beats after R_DONE are refused.
    assign rBeat = axi_r_valid && (rState_q == R_DATA);

    always_comb begin
        rState_d = rState_q;
        rAddr_d  = rAddr_q;
        rSize_d  = rSize_q;
        rLen_d   = rLen_q;
        rCnt_d   = rCnt_q;
        rData_d  = rData_q;
        case (rState_q)
            R_IDLE: begin
                if (r_valid_i) begin
                    rAddr_d  = r_addr_i;
                    rSize_d  = clampSize(r_size_i[2:0]);
                    rLen_d   = (r_len_i > 8'(MAX_LEN)) ? 8'(MAX_LEN) : r_len_i;
                    rCnt_d   = '0;
                    rState_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (axi_ar_ready) rState_d = R_DATA;
            end
            R_DATA: begin
                if (rBeat) begin
                    rData_d = axi_r_data;
                    rCnt_d  = rCnt_q + 8'd1;
                    // Either an early r_last or the expected beat count ends the burst.
                    if (axi_r_last || (rCnt_q == rLen_q)) rState_d = R_DONE;
                end
            end
            R_DONE: begin
                // Deliberately ignores r_valid_i so a still-held request is not re-issued.
                rState_d = R_IDLE;
            end
            default: rState_d = R_IDLE;
        endcase
    end

    assign axi_ar_valid = (rState_q == R_ADDR);
    assign axi_ar_addr  = rAddr_q;
    assign axi_ar_id    = '0;
    assign axi_ar_len   = rLen_q;
    assign axi_ar_size  = rSize_q;
    assign axi_ar_burst = 2'b01;
    assign axi_r_ready  = (rState_q == R_DATA);
    assign r_ready_o    = (rState_q == R_DONE);
    assign data_read_o  = rData_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wState_q <= W_IDLE;
            wAddr_q  <= '0;
            wData_q  <= '0;
            wSize_q  <= '0;
            wStrb_q  <= '0;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
        end else begin
            wState_q <= wState_d;
            wAddr_q  <= wAddr_d;
            wData_q  <= wData_d;
            wSize_q  <= wSize_d;
            wStrb_q  <= wStrb_d;
            awDone_q <= awDone_d;
            wDone_q  <= wDone_d;
        end
    end

    // Byte-lane mask for the clamped size, shifted to the address lane and truncated to 8 lanes.
    always_comb begin
        laneMask = 8'h00;
        case (clampSize(w_size_i[2:0]))
            3'd0:    laneMask = 8'h01;
            3'd1:    laneMask = 8'h03;
            3'd2:    laneMask = 8'h0F;
            default: laneMask = 8'hFF;
        endcase
        strbWide = {8'h00, laneMask} << w_addr_i[2:0];
    end

    // AW and W complete independently; each flag remembers its own handshake.
    assign awDoneNow = awDone_q || (axi_aw_valid && axi_aw_ready);
    assign wDoneNow  = wDone_q  || (axi_w_valid  && axi_w_ready);

    always_comb begin
        wState_d = wState_q;
        wAddr_d  = wAddr_q;
        wData_d  = wData_q;
        wSize_d  = wSize_q;
        wStrb_d  = wStrb_q;
        awDone_d = awDone_q;
        wDone_d  = wDone_q;
        case (wState_q)
            W_IDLE: begin
                if (w_valid_i) begin
                    wAddr_d  = w_addr_i;
                    wData_d  = rw_w_data_i;
                    wSize_d  = clampSize(w_size_i[2:0]);
                    wStrb_d  = STRB_W'(strbWide[7:0]);
                    awDone_d = 1'b0;
                    wDone_d  = 1'b0;
                    wState_d = W_REQ;
                end
            end
            W_REQ: begin
                if (awDoneNow && wDoneNow) begin
                    awDone_d = 1'b0;
                    wDone_d  = 1'b0;
                    wState_d = W_RESP;
                end else begin
                    awDone_d = awDoneNow;
                    wDone_d  = wDoneNow;
                end
            end
            W_RESP: begin
                if (axi_b_valid) wState_d = W_DONE;
            end
            W_DONE: wState_d = W_IDLE;
            default: wState_d = W_IDLE;
        endcase
    end

    assign axi_aw_valid = (wState_q == W_REQ) && !awDone_q;
    assign axi_aw_addr  = wAddr_q;
    assign axi_aw_id    = '0;
    assign axi_aw_len   = 8'd0;
    assign axi_aw_size  = wSize_q;
    assign axi_aw_burst = 2'b01;
    assign axi_w_valid  = (wState_q == W_REQ) && !wDone_q;
    assign axi_w_data   = wData_q;
    assign axi_w_strb   = wStrb_q;
    assign axi_w_last   = 1'b1;
    assign axi_b_ready  = (wState_q == W_RESP);
    assign w_ready_o    = (wState_q == W_DONE);

`ifdef AXI_RESP_CHECK_EN
    logic respErr_q, respErr_d;

    // Sticky until reset; the erroring transaction itself still completes.
    always_comb begin
        respErr_d = respErr_q;
        if ((rBeat && (axi_r_resp != 2'b00)) ||
            (axi_b_valid && axi_b_ready && (axi_b_resp != 2'b00)))
            respErr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) respErr_q <= 1'b0;
        else     respErr_q <= respErr_d;
    end

    assign resp_err_o = respErr_q;

    logic unusedInputs;
    assign unusedInputs = ^{r_size_i[7:3], w_size_i[7:3], w_len_i, axi_r_id, axi_b_id};
`else
    logic unusedInputs;
    assign unusedInputs = ^{r_size_i[7:3], w_size_i[7:3], w_len_i, axi_r_id, axi_b_id,
                            axi_r_resp, axi_b_resp};
`endif

endmodule
